axi_rd_arbiter: RTL and testbench

//  Two-master read arbiter between I-cache and D-cache refill ports and the single AXI AR/R channel.

---
 rtl/axi_rd_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master (I-cache / D-cache) read arbiter onto a single AXI AR/R channel, one burst in flight.
// Define ARB_RR_EN for round-robin tie-breaking; default build is fixed priority with D-cache winning ties.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [2:0]        i_size,
  output logic              i_addr_ok,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_rlast,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_len,
  input  logic [2:0]        d_size,
  output logic              d_addr_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_rlast,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [ID_W-1:0] ID_I = '0;
  localparam logic [ID_W-1:0] ID_D = {{(ID_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic              gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [ID_W-1:0]   id_q;
  logic              pick_d;
  logic              burst_done;
  logic              r_to_i;
  logic              r_to_d;

  assign burst_done = (state == S_R) && rvalid && rlast;

`ifdef ARB_RR_EN
  logic last_gnt;

  // On a tie the master that did not own the previous burst wins.
  always_comb begin
    pick_d = d_req && (!i_req || (last_gnt == GNT_I));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= GNT_I;
    end else if (burst_done) begin
      last_gnt <= gnt;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Request parameters are captured in IDLE so AR stays stable however long arready is held off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt    <= GNT_I;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      id_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            gnt    <= pick_d ? GNT_D : GNT_I;
            addr_q <= pick_d ? d_addr : i_addr;
            len_q  <= pick_d ? d_len : i_len;
            size_q <= pick_d ? d_size : i_size;
            id_q   <= pick_d ? ID_D : ID_I;
            state  <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            state <= S_R;
          end
        end
        S_R: begin
          if (burst_done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // valid/ready: a transfer happens on a cycle where both are high; arvalid never drops before arready.
  assign arvalid   = (state == S_AR);
  assign arid      = id_q;
  assign araddr    = addr_q;
  assign arlen     = len_q;
  assign arsize    = size_q;
  assign rready    = (state == S_R);
  assign state_dbg = state;

  assign i_addr_ok = arvalid && arready && (gnt == GNT_I);
  assign d_addr_ok = arvalid && arready && (gnt == GNT_D);

  assign r_to_i = (state == S_R) && (gnt == GNT_I);
  assign r_to_d = (state == S_R) && (gnt == GNT_D);

  assign i_rvalid = r_to_i && rvalid;
  assign i_rlast  = r_to_i && rlast;
  assign i_rdata  = r_to_i ? rdata : '0;
  assign d_rvalid = r_to_d && rvalid;
  assign d_rlast  = r_to_d && rlast;
  assign d_rdata  = r_to_d ? rdata : '0;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus a randomized run, all checked against a burst-level model.
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [7:0]        i_len = '0;
  logic [2:0]        i_size = '0;
  logic              i_addr_ok;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_rlast;
  logic              d_req = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [7:0]        d_len = '0;
  logic [2:0]        d_size = '0;
  logic              d_addr_ok;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_rlast;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic              rlast = 1'b0;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [1:0]        state_dbg;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_size(i_size),
    .i_addr_ok(i_addr_ok), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size),
    .d_addr_ok(d_addr_ok), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  int          p_newreq = 0;
  int          p_ready = 100;
  int          p_rvalid = 100;
  int          fixed_len = -1;
  int          ready_low = 0;
  bit          rst_req = 1'b0;
  bit          force_data = 1'b0;
  logic [31:0] forced_data = '0;

  // requesting masters: a request is held until its address is accepted
  bit i_pend = 1'b0;
  bit d_pend = 1'b0;

  // reference model: the burst currently owning the bus
  bit          b_active = 1'b0;
  bit          b_issued = 1'b0;
  bit          b_who = 1'b0;
  logic [31:0] b_addr = '0;
  logic [7:0]  b_len = '0;
  logic [2:0]  b_size = '0;
  int          b_beats = 0;
  bit          last_who = 1'b0;

  // observations
  int              cnt_i_ok = 0;
  int              cnt_d_ok = 0;
  int              cnt_i_beats = 0;
  int              cnt_d_beats = 0;
  logic [ID_W-1:0] ar_log[$];
  logic [ID_W-1:0] exp_q[$];

  // expected outputs for the current cycle
  bit e_arvalid, e_rready, e_i_ok, e_d_ok, e_to_i, e_to_d;

  function automatic bit choose_d(input bit ireq, input bit dreq, input bit last);
    if (ireq && dreq) begin
`ifdef ARB_RR_EN
      return (last == 1'b0);
`else
      return 1'b1;
`endif
    end
    return dreq;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic req_i(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    i_pend = 1'b1; i_addr = a; i_len = l; i_size = s;
  endtask

  task automatic req_d(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    d_pend = 1'b1; d_addr = a; d_len = l; d_size = s;
  endtask

  task automatic drive();
    rst = rst_req;
    if (!i_pend && $urandom_range(0, 99) < p_newreq)
      req_i($urandom(), (fixed_len < 0) ? 8'($urandom_range(0, 5)) : 8'(fixed_len), 3'($urandom_range(0, 2)));
    if (!d_pend && $urandom_range(0, 99) < p_newreq)
      req_d($urandom(), (fixed_len < 0) ? 8'($urandom_range(0, 5)) : 8'(fixed_len), 3'($urandom_range(0, 2)));
    i_req = i_pend;
    d_req = d_pend;
    arready = (ready_low > 0) ? 1'b0 : ($urandom_range(0, 99) < p_ready);
    rvalid  = ($urandom_range(0, 99) < p_rvalid);
    rdata   = force_data ? forced_data : $urandom();
    rlast   = (b_active && b_issued) ? (b_beats == int'(b_len)) : 1'($urandom_range(0, 1));
  endtask

  task automatic cycle_begin();
    drive();
    #1;
  endtask

  task automatic cycle_end();
    e_arvalid = b_active && !b_issued;
    e_rready  = b_active && b_issued;
    e_i_ok    = e_arvalid && arready && (b_who == 1'b0);
    e_d_ok    = e_arvalid && arready && (b_who == 1'b1);
    e_to_i    = e_rready && (b_who == 1'b0);
    e_to_d    = e_rready && (b_who == 1'b1);
    check("arvalid", arvalid, e_arvalid);
    check("rready", rready, e_rready);
    check("i_addr_ok", i_addr_ok, e_i_ok);
    check("d_addr_ok", d_addr_ok, e_d_ok);
    check("i_rvalid", i_rvalid, e_to_i && rvalid);
    check("i_rlast", i_rlast, e_to_i && rlast);
    check("i_rdata", i_rdata, e_to_i ? rdata : 32'h0);
    check("d_rvalid", d_rvalid, e_to_d && rvalid);
    check("d_rlast", d_rlast, e_to_d && rlast);
    check("d_rdata", d_rdata, e_to_d ? rdata : 32'h0);
    if (e_arvalid) begin
      check("arid", arid, {3'b000, b_who});
      check("araddr", araddr, b_addr);
      check("arlen", arlen, b_len);
      check("arsize", arsize, b_size);
    end
    if (arvalid && arready) ar_log.push_back(arid);
    if (i_addr_ok) cnt_i_ok++;
    if (d_addr_ok) cnt_d_ok++;
    if (i_rvalid) cnt_i_beats++;
    if (d_rvalid) cnt_d_beats++;

    // advance the model across the coming clock edge
    if (rst) begin
      b_active = 1'b0; b_issued = 1'b0; b_who = 1'b0;
      b_addr = '0; b_len = '0; b_size = '0; b_beats = 0;
      last_who = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
    end else begin
      if (e_i_ok) i_pend = 1'b0;
      if (e_d_ok) d_pend = 1'b0;
      if (e_arvalid && ready_low > 0) ready_low--;
      if (!b_active) begin
        if (i_req || d_req) begin
          b_who    = choose_d(i_req, d_req, last_who);
          b_addr   = b_who ? d_addr : i_addr;
          b_len    = b_who ? d_len : i_len;
          b_size   = b_who ? d_size : i_size;
          b_active = 1'b1;
          b_issued = 1'b0;
          b_beats  = 0;
        end
      end else if (!b_issued) begin
        if (arready) b_issued = 1'b1;
      end else if (rvalid) begin
        b_beats++;
        if (b_beats > int'(b_len)) begin
          b_active = 1'b0;
          last_who = b_who;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    cycle_begin();
    cycle_end();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    p_newreq = 0;
    for (k = 0; k < 300 && (b_active || i_pend || d_pend); k++) cycle();
    check(tag, (b_active || i_pend || d_pend), 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    @(negedge clk);
    do_reset();

    // reset state
    cycle_begin();
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_arlen", arlen, 8'h0);
    check("rst_arsize", arsize, 3'h0);
    check("rst_arid", arid, 4'h0);
    cycle_end();

    // 1: lone I-cache burst, arready held high
    p_ready = 100; p_rvalid = 100;
    cnt_i_beats = 0; cnt_d_beats = 0;
    req_i(32'h1FC0_0000, 8'd7, 3'd2);
    cycle();
    cycle_begin();
    check("t1_arvalid", arvalid, 1'b1);
    check("t1_arid", arid, 4'd0);
    check("t1_araddr", araddr, 32'h1FC0_0000);
    check("t1_arlen", arlen, 8'd7);
    check("t1_i_ok", i_addr_ok, 1'b1);
    cycle_end();
    for (int k = 0; k < 8; k++) begin
      cycle_begin();
      check("t1_i_rvalid", i_rvalid, 1'b1);
      check("t1_i_rlast", i_rlast, k == 7);
      check("t1_d_rvalid", d_rvalid, 1'b0);
      cycle_end();
    end
    cycle_begin();
    check("t1_idle_rready", rready, 1'b0);
    cycle_end();
    check("t1_i_beats", cnt_i_beats, 8);
    check("t1_d_beats", cnt_d_beats, 0);

    // 2: simultaneous requests, D wins first (last owner was I)
    ar_log.delete();
    req_i(32'h0000_1000, 8'd1, 3'd2);
    req_d(32'h0000_2000, 8'd1, 3'd2);
    for (int k = 0; k < 40 && ar_log.size() < 2; k++) cycle();
    check("t2_count", ar_log.size(), 2);
    if (ar_log.size() >= 2) begin
      check("t2_first", ar_log[0], 4'd1);
      check("t2_second", ar_log[1], 4'd0);
    end
    drain("t2_drain");

    // 3: both masters requesting continuously, len=3
    do_reset();
    ar_log.delete();
    fixed_len = 3; p_newreq = 100;
`ifdef ARB_RR_EN
    exp_q = '{4'd1, 4'd0, 4'd1, 4'd0};
`else
    exp_q = '{4'd1, 4'd1, 4'd1, 4'd1};
`endif
    for (int k = 0; k < 200 && ar_log.size() < 4; k++) cycle();
    check("t3_count", ar_log.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < ar_log.size(); k++) check("t3_grant", ar_log[k], exp_q[k]);
    fixed_len = -1;
    drain("t3_drain");

    // 4: arready held low for 5 cycles
    cnt_d_ok = 0;
    req_d(32'hA000_0040, 8'd2, 3'd3);
    ready_low = 5;
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle_begin();
      check("t4_arvalid", arvalid, 1'b1);
      check("t4_araddr", araddr, 32'hA000_0040);
      check("t4_arlen", arlen, 8'd2);
      check("t4_arsize", arsize, 3'd3);
      check("t4_arid", arid, 4'd1);
      check("t4_no_ok", d_addr_ok, 1'b0);
      cycle_end();
    end
    cycle_begin();
    check("t4_ok", d_addr_ok, 1'b1);
    cycle_end();
    drain("t4_drain");
    check("t4_ok_once", cnt_d_ok, 1);

    // 5: reset at the second beat of a D burst
    cnt_d_beats = 0;
    req_d(32'h0000_0080, 8'd3, 3'd2);
    for (int k = 0; k < 20 && cnt_d_beats < 1; k++) cycle();
    check("t5_first_beat", cnt_d_beats, 1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle_begin();
    check("t5_arvalid", arvalid, 1'b0);
    check("t5_rready", rready, 1'b0);
    check("t5_d_rvalid", d_rvalid, 1'b0);
    cycle_end();
    cnt_i_ok = 0;
    req_i(32'h0000_0100, 8'd1, 3'd2);
    for (int k = 0; k < 10 && cnt_i_ok < 1; k++) cycle();
    check("t5_i_ok", cnt_i_ok, 1);
    drain("t5_drain");

    // 6: single-beat D read
    force_data = 1'b1; forced_data = 32'hDEAD_BEEF;
    req_d(32'h0000_0200, 8'd0, 3'd2);
    cycle();
    cycle();
    cycle_begin();
    check("t6_d_rvalid", d_rvalid, 1'b1);
    check("t6_d_rlast", d_rlast, 1'b1);
    check("t6_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check("t6_i_rvalid", i_rvalid, 1'b0);
    cycle_end();
    cycle_begin();
    check("t6_idle_rready", rready, 1'b0);
    check("t6_idle_d_rvalid", d_rvalid, 1'b0);
    cycle_end();
    force_data = 1'b0;

    // randomized traffic with back-pressure, gaps and occasional reset
    p_newreq = 30; p_ready = 60; p_rvalid = 70;
    for (int k = 0; k < 4000; k++) begin
      rst_req = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst_req = 1'b0;
    p_ready = 100; p_rvalid = 100;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
